mem_wb_stage: RTL and testbench

- Memory stage of the 5-stage MIPS pipeline, directly downstream of the EX/MEM pipeline register.
- Consumes the M_* bundle, resolves the branch select, and performs load/store over a variable-latency data-memory handshake.
- Stalls the upstream pipeline while an access is outstanding, then registers results into the MEM/WB boundary (W_* outputs) for writeback.

---
 rtl/mem_wb_stage_pkg.sv | 17 +
 rtl/mem_wb_stage_dmem_if_fsm.sv | 103 ++++++++++
 rtl/mem_wb_stage.sv | 137 +++++++++++++
 tb/tb_mem_wb_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MIPS memory stage: FSM encoding, default widths
// and a small address helper used by the stage and its memory interface.
package mem_wb_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W      = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_e;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/mem_wb_stage_dmem_if_fsm.sv
// Data-memory handshake: launches one request per access, waits for ack with a
// saturating timeout, and reports completion to the MEM/WB register.
module dmem_if_fsm
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              dmem_ack_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic              timed_out_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // Pipeline-wide convention: state advances on the falling edge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        stall_o     = 1'b0;
        done_o      = 1'b0;
        timed_out_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    stall_o = 1'b1;
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                // An ack arriving on the final allowed cycle still counts as success.
                if (dmem_ack_i) begin
                    done_o  = 1'b1;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    timed_out_o = 1'b1;
                    req_d       = 1'b0;
                    state_d     = IDLE;
                end else begin
                    stall_o = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rdata_o      = (done_o && !we_q) ? dmem_rdata_i : '0;
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage of the 5-stage MIPS pipeline: branch select, load/store through the
// data-memory handshake, and the MEM/WB boundary register with sticky error flags.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] M_ALUresult,
    input  logic [DATA_W-1:0] M_memData,
    input  logic [DATA_W-1:0] M_addi,
    input  logic [REG_W-1:0]  M_writeReg,
    input  logic              M_RegWrite,
    input  logic              M_MemtoReg,
    input  logic              M_Branch,
    input  logic              M_MemRead,
    input  logic              M_MemWrite,
    input  logic              M_zero,
    output logic              pcsrc,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] W_ALUresult,
    output logic [DATA_W-1:0] W_memData,
    output logic [DATA_W-1:0] W_addi,
    output logic [REG_W-1:0]  W_writeReg,
    output logic              W_RegWrite,
    output logic              W_MemtoReg,
    output logic              bus_err,
    output logic              misalign_err
);

    logic              ldst, access, misalign;
    logic              stall, done, timed_out;
    logic [DATA_W-1:0] fsm_rdata;

    logic [DATA_W-1:0] w_alu_q, w_alu_d;
    logic [DATA_W-1:0] w_memd_q, w_memd_d;
    logic [DATA_W-1:0] w_addi_q, w_addi_d;
    logic [REG_W-1:0]  w_wreg_q, w_wreg_d;
    logic              w_rw_q, w_rw_d;
    logic              w_mtr_q, w_mtr_d;
    logic              bus_err_q, bus_err_d;
    logic              misalign_err_q, misalign_err_d;

    assign pcsrc    = M_Branch & M_zero;
    assign ldst     = M_MemRead | M_MemWrite;
    assign access   = ldst & word_aligned(M_ALUresult[1:0]);
    assign misalign = ldst & ~word_aligned(M_ALUresult[1:0]);

    // Read+write together is resolved as a write by steering we from M_MemWrite.
    dmem_if_fsm #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_dmem_if (
        .clk          (clk),
        .rst          (rst),
        .start_i      (access),
        .we_i         (M_MemWrite),
        .addr_i       (M_ALUresult),
        .wdata_i      (M_memData),
        .dmem_ack_i   (dmem_ack),
        .dmem_rdata_i (dmem_rdata),
        .stall_o      (stall),
        .done_o       (done),
        .timed_out_o  (timed_out),
        .rdata_o      (fsm_rdata),
        .dmem_req_o   (dmem_req),
        .dmem_we_o    (dmem_we),
        .dmem_addr_o  (dmem_addr),
        .dmem_wdata_o (dmem_wdata)
    );

    assign mem_stall = stall;

    // While stalled, only the write enable is squashed so WB sees a bubble.
    always_comb begin
        w_alu_d        = w_alu_q;
        w_memd_d       = w_memd_q;
        w_addi_d       = w_addi_q;
        w_wreg_d       = w_wreg_q;
        w_rw_d         = w_rw_q;
        w_mtr_d        = w_mtr_q;
        bus_err_d      = bus_err_q | timed_out;
        misalign_err_d = misalign_err_q | misalign;
        if (stall) begin
            w_rw_d = 1'b0;
        end else begin
            w_alu_d  = M_ALUresult;
            w_memd_d = fsm_rdata;
            w_addi_d = M_addi;
            w_wreg_d = M_writeReg;
            w_mtr_d  = M_MemtoReg;
            w_rw_d   = M_RegWrite & ~misalign & ~timed_out;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            w_alu_q        <= '0;
            w_memd_q       <= '0;
            w_addi_q       <= '0;
            w_wreg_q       <= '0;
            w_rw_q         <= 1'b0;
            w_mtr_q        <= 1'b0;
            bus_err_q      <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            w_alu_q        <= w_alu_d;
            w_memd_q       <= w_memd_d;
            w_addi_q       <= w_addi_d;
            w_wreg_q       <= w_wreg_d;
            w_rw_q         <= w_rw_d;
            w_mtr_q        <= w_mtr_d;
            bus_err_q      <= bus_err_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    assign W_ALUresult  = w_alu_q;
    assign W_memData    = w_memd_q;
    assign W_addi       = w_addi_q;
    assign W_writeReg   = w_wreg_q;
    assign W_RegWrite   = w_rw_q;
    assign W_MemtoReg   = w_mtr_q;
    assign bus_err      = bus_err_q;
    assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed vectors push expected MEM/WB
// contents; a monitor checks them on every committing falling edge.
`timescale 1ns/1ps
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] M_ALUresult, M_memData, M_addi;
    logic [4:0]  M_writeReg;
    logic        M_RegWrite, M_MemtoReg, M_Branch, M_MemRead, M_MemWrite, M_zero;
    logic        pcsrc, mem_stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] W_ALUresult, W_memData, W_addi;
    logic [4:0]  W_writeReg;
    logic        W_RegWrite, W_MemtoReg, bus_err, misalign_err;

    mem_wb_stage #(.DATA_W(32), .TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .M_ALUresult(M_ALUresult), .M_memData(M_memData), .M_addi(M_addi),
        .M_writeReg(M_writeReg), .M_RegWrite(M_RegWrite), .M_MemtoReg(M_MemtoReg),
        .M_Branch(M_Branch), .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite),
        .M_zero(M_zero), .pcsrc(pcsrc), .mem_stall(mem_stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .W_ALUresult(W_ALUresult), .W_memData(W_memData), .W_addi(W_addi),
        .W_writeReg(W_writeReg), .W_RegWrite(W_RegWrite), .W_MemtoReg(W_MemtoReg),
        .bus_err(bus_err), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] memd;
        logic [31:0] addi;
        logic [4:0]  wreg;
        logic        rw;
        logic        mtr;
    } wb_t;

    wb_t exp_q[$];
    wb_t mon_e;
    int  n_cmp  = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;
    bit  pre_ok = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    function automatic wb_t mk(input logic [31:0] alu, memd, addi,
                               input logic [4:0] wreg, input logic rw, mtr);
        wb_t e;
        e.alu = alu; e.memd = memd; e.addi = addi; e.wreg = wreg; e.rw = rw; e.mtr = mtr;
        return e;
    endfunction

    // A falling edge commits M_* into W_* whenever the stage was not stalled.
    always @(posedge clk) pre_ok <= mon_en && !rst && !mem_stall;

    always @(negedge clk) begin
        if (pre_ok) begin
            #1;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_commit: got W_ALUresult 0x%08h, expected no commit", W_ALUresult);
            end else begin
                mon_e = exp_q.pop_front();
                chk("W_ALUresult", W_ALUresult, mon_e.alu);
                chk("W_memData", W_memData, mon_e.memd);
                chk("W_addi", W_addi, mon_e.addi);
                chk("W_writeReg", 32'(W_writeReg), 32'(mon_e.wreg));
                chk("W_RegWrite", 32'(W_RegWrite), 32'(mon_e.rw));
                chk("W_MemtoReg", 32'(W_MemtoReg), 32'(mon_e.mtr));
            end
        end
    end

    task automatic set_m(input logic [31:0] alu, md, addi, input logic [4:0] wr,
                         input logic rw, mtr, rd, wrt);
        M_ALUresult = alu; M_memData = md; M_addi = addi; M_writeReg = wr;
        M_RegWrite = rw; M_MemtoReg = mtr; M_MemRead = rd; M_MemWrite = wrt;
        M_Branch = 1'b0; M_zero = 1'b0;
    endtask

    // Called just after a falling edge; returns just after the committing edge.
    task automatic do_vec(input string name, input logic [31:0] alu, md, addi,
                          input logic [4:0] wr, input logic rw, mtr, rd, wrt,
                          input int ack_after, input bit ack_idle, input logic [31:0] rdata,
                          input bit exp_req, input logic exp_we, input int exp_stall, input wb_t e);
        int stalls = 0;
        int busy   = 0;
        bit seen   = 1'b0;
        bit fin    = 1'b0;
        set_m(alu, md, addi, wr, rw, mtr, rd, wrt);
        exp_q.push_back(e);
        for (int k = 0; k < 40 && !fin; k++) begin
            dmem_ack   = dmem_req ? (busy == ack_after) : ack_idle;
            dmem_rdata = dmem_ack ? rdata : 32'h0;
            @(posedge clk);
            if (dmem_req && !seen) begin
                seen = 1'b1;
                chk({name, "_dmem_we"}, 32'(dmem_we), 32'(exp_we));
                chk({name, "_dmem_addr"}, dmem_addr, alu);
                if (exp_we) chk({name, "_dmem_wdata"}, dmem_wdata, md);
                chk({name, "_W_RegWrite_wait"}, 32'(W_RegWrite), 32'h0);
            end
            if (dmem_req) busy++;
            if (mem_stall) stalls++;
            else fin = 1'b1;
            @(negedge clk);
            #1;
        end
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        if (!fin) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_complete: got no completion in 40 cycles, expected completion", name);
        end
        chk({name, "_req_seen"}, 32'(seen), 32'(exp_req));
        chk({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    endtask

    initial begin
        rst = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        set_m(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_W_ALUresult", W_ALUresult, 32'h0);
        chk("rst_W_RegWrite", 32'(W_RegWrite), 32'h0);
        chk("rst_dmem_req", 32'(dmem_req), 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_misalign_err", 32'(misalign_err), 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;

        do_vec("rtype", 32'h1234, 32'h99, 32'h11, 5'd5, 1, 0, 0, 0, 0, 0, 32'h0,
               0, 0, 0, mk(32'h1234, 32'h0, 32'h11, 5'd5, 1, 0));
        do_vec("load", 32'h40, 32'h0, 32'h7, 5'd8, 1, 1, 1, 0, 3, 0, 32'hDEADBEEF,
               1, 0, 4, mk(32'h40, 32'hDEADBEEF, 32'h7, 5'd8, 1, 1));
        do_vec("store", 32'h80, 32'hA5A5A5A5, 32'h3, 5'd0, 0, 0, 0, 1, 1, 0, 32'h5555,
               1, 1, 2, mk(32'h80, 32'h0, 32'h3, 5'd0, 0, 0));
        do_vec("rdwr", 32'h84, 32'h0F0F0F0F, 32'h5, 5'd6, 0, 0, 1, 1, 0, 0, 32'h12345678,
               1, 1, 1, mk(32'h84, 32'h0, 32'h5, 5'd6, 0, 0));
        chk("bus_err_before_timeout", 32'(bus_err), 32'h0);
        do_vec("timeout", 32'h100, 32'h0, 32'h21, 5'd9, 1, 1, 1, 0, 99, 0, 32'hBAD,
               1, 0, 16, mk(32'h100, 32'h0, 32'h21, 5'd9, 0, 1));
        chk("timeout_bus_err", 32'(bus_err), 32'h1);
        chk("timeout_dmem_req", 32'(dmem_req), 32'h0);
        do_vec("misalign", 32'h42, 32'h0, 32'h2, 5'd3, 1, 1, 1, 0, 0, 0, 32'h0,
               0, 0, 0, mk(32'h42, 32'h0, 32'h2, 5'd3, 0, 1));
        chk("misalign_err", 32'(misalign_err), 32'h1);
        chk("misalign_dmem_req", 32'(dmem_req), 32'h0);
        do_vec("idle_ack", 32'hCAFE, 32'h0, 32'h44, 5'd31, 1, 0, 0, 0, 0, 1, 32'hFFFF,
               0, 0, 0, mk(32'hCAFE, 32'h0, 32'h44, 5'd31, 1, 0));
        chk("bus_err_sticky", 32'(bus_err), 32'h1);
        chk("misalign_err_sticky", 32'(misalign_err), 32'h1);

        mon_en = 1'b0;
        set_m(32'h200, 32'h0, 32'h1, 5'd4, 1, 1, 1, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        @(posedge clk);
        chk("midbusy_dmem_req", 32'(dmem_req), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy_dmem_req", 32'(dmem_req), 32'h0);
        chk("rst_busy_W_ALUresult", W_ALUresult, 32'h0);
        chk("rst_busy_W_addi", W_addi, 32'h0);
        chk("rst_busy_W_writeReg", 32'(W_writeReg), 32'h0);
        chk("rst_busy_bus_err", 32'(bus_err), 32'h0);
        chk("rst_busy_misalign_err", 32'(misalign_err), 32'h0);
        set_m(32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        do_vec("post_rst", 32'h77, 32'h0, 32'h8, 5'd2, 1, 0, 0, 0, 0, 0, 32'h0,
               0, 0, 0, mk(32'h77, 32'h0, 32'h8, 5'd2, 1, 0));
        mon_en = 1'b0;

        M_Branch = 1'b1; M_zero = 1'b1;
        #1 chk("pcsrc_taken", 32'(pcsrc), 32'h1);
        M_zero = 1'b0;
        #1 chk("pcsrc_not_taken", 32'(pcsrc), 32'h0);
        @(negedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL leftover_expected: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
